// File: rtl/bitlogic_pkg.sv
// Shared operation encoding and the bitwise operator used by bitlogic_pipe.
// apply_op works on a MAX_W-wide vector; callers zero-extend and narrow to their WIDTH.
package bitlogic_pkg;

   localparam int MAX_W = 1024;

   typedef enum logic [1:0] {
      OP_AND  = 2'd0,
      OP_OR   = 2'd1,
      OP_XOR  = 2'd2,
      OP_ANDN = 2'd3
   } op_e;

   // Purely bitwise, so bit i of the result depends only on bit i of x and y.
   function automatic logic [MAX_W-1:0] apply_op(input op_e op,
                                                 input logic [MAX_W-1:0] x,
                                                 input logic [MAX_W-1:0] y);
      logic [MAX_W-1:0] r;
      case (op)
         OP_AND:  r = x & y;
         OP_OR:   r = x | y;
         OP_XOR:  r = x ^ y;
         OP_ANDN: r = x & ~y;
         default: r = x & y;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/bitlogic_pipe_stage.sv
// Generic valid/ready pipeline register for an opaque payload vector.
// Accepts a new beat whenever it is empty or its current beat is being drained.
module bitlogic_pipe_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         vld_p;
   logic [W-1:0] data_p;

   assign in_ready  = !vld_p || out_ready;
   assign out_valid = vld_p;
   assign out_data  = data_p;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p  <= 1'b0;
         data_p <= '0;
      end else if (in_ready) begin
         vld_p <= in_valid;
         if (in_valid) begin
            data_p <= in_data;
         end
      end
   end

endmodule

// File: rtl/bitlogic_pipe.sv
// Pipelined two-operand bitwise unit with an optional burst accumulator.
// Stage 1 registers the operands and computes/folds; stage 2 (PIPE_OUT=1) registers the result.
module bitlogic_pipe
   import bitlogic_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int PIPE_OUT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_op,
   input  logic             in_acc,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last
);

   localparam int PW = 2*WIDTH + 4;

   logic             s1_in_ready;
   logic             s1_down_ready;
   logic             s1_advance;
   logic             vld_p1;
   logic [PW-1:0]    pay_p1;
   logic [WIDTH-1:0] a_p1;
   logic [WIDTH-1:0] b_p1;
   op_e              op_p1;
   logic             acc_p1;
   logic             last_p1;
   logic [WIDTH-1:0] r_p1;
   logic [WIDTH-1:0] fold_p1;
   logic [WIDTH-1:0] res_p1;
   logic [WIDTH-1:0] acc_reg;
   logic             first;

   // ---- stage 1: operand register ----
   bitlogic_pipe_stage #(.W(PW)) u_stage1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (s1_in_ready),
      .in_data   ({in_a, in_b, in_op, in_acc, in_last}),
      .out_valid (vld_p1),
      .out_ready (s1_down_ready),
      .out_data  (pay_p1)
   );

   // Held high through reset; anything accepted then is wiped by the reset itself.
   assign in_ready = s1_in_ready || !rst_n;

   assign a_p1    = pay_p1[PW-1 -: WIDTH];
   assign b_p1    = pay_p1[WIDTH+3 -: WIDTH];
   assign op_p1   = op_e'(pay_p1[3:2]);
   assign acc_p1  = pay_p1[1];
   assign last_p1 = pay_p1[0];

   assign r_p1    = WIDTH'(apply_op(op_p1, MAX_W'(a_p1), MAX_W'(b_p1)));
   assign fold_p1 = WIDTH'(apply_op(op_p1, MAX_W'(acc_reg), MAX_W'(r_p1)));
   assign res_p1  = (acc_p1 && !first) ? fold_p1 : r_p1;

   assign s1_advance = vld_p1 && s1_down_ready;

   // Accumulator only moves when the beat actually leaves stage 1, so stalls never double-fold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_reg <= '0;
         first   <= 1'b1;
      end else if (s1_advance) begin
         if (acc_p1) begin
            acc_reg <= res_p1;
         end
         first <= last_p1;
      end
   end

   // ---- stage 2: optional result register ----
   generate
      if (PIPE_OUT != 0) begin : g_out_reg
         logic [WIDTH:0] pay_p2;

         bitlogic_pipe_stage #(.W(WIDTH+1)) u_stage2 (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (vld_p1),
            .in_ready  (s1_down_ready),
            .in_data   ({res_p1, last_p1}),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (pay_p2)
         );

         assign out_data = pay_p2[WIDTH:1];
         assign out_last = pay_p2[0];
      end else begin : g_out_comb
         assign s1_down_ready = out_ready;
         assign out_valid     = vld_p1;
         assign out_data      = res_p1;
         assign out_last      = last_p1;
      end
   endgenerate

endmodule

// File: tb/tb_bitlogic_pipe.sv
// Bench for bitlogic_pipe: directed and random beats against an in-order reference model.
`timescale 1ns/1ps
module tb_bitlogic_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_a = '0;
   logic [7:0]  in_b = '0;
   logic [1:0]  in_op = '0;
   logic        in_acc = 1'b0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_data;
   logic        out_last;

   logic        in_valid2 = 1'b0;
   logic        in_ready2;
   logic [31:0] in_a2 = '0;
   logic [31:0] in_b2 = '0;
   logic [1:0]  in_op2 = '0;
   logic        in_acc2 = 1'b0;
   logic        in_last2 = 1'b0;
   logic        out_valid2;
   logic        out_ready2 = 1'b1;
   logic [31:0] out_data2;
   logic        out_last2;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bitlogic_pipe #(.WIDTH(8), .PIPE_OUT(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last)
   );

   bitlogic_pipe #(.WIDTH(32), .PIPE_OUT(0)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid2), .in_ready(in_ready2),
      .in_a(in_a2), .in_b(in_b2), .in_op(in_op2), .in_acc(in_acc2), .in_last(in_last2),
      .out_valid(out_valid2), .out_ready(out_ready2),
      .out_data(out_data2), .out_last(out_last2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: results computed in acceptance order from the operation rules.
   typedef struct {
      logic [7:0] d;
      logic       l;
      int         acc_cyc;
   } exp_t;

   exp_t       mq[$];
   logic [7:0] got[$];
   logic       got_last[$];
   logic [7:0] m_acc = '0;
   logic       m_first = 1'b1;
   logic       stall_prev = 1'b0;
   logic [7:0] hold_d = '0;
   logic       hold_l = 1'b0;

   function automatic logic [7:0] ref_op(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
      case (op)
         2'd0:    return x & y;
         2'd1:    return x | y;
         2'd2:    return x ^ y;
         default: return x & ~y;
      endcase
   endfunction

   always @(negedge clk) begin
      exp_t       e;
      logic       exp_v;
      logic [7:0] r;
      if (!rst_n) begin
         mq.delete();
         m_acc      = '0;
         m_first    = 1'b1;
         stall_prev = 1'b0;
      end else begin
         exp_v = (mq.size() > 0) ? (mq[0].acc_cyc + 2 <= cyc) : 1'b0;
         chk("out_valid timing", 32'(out_valid), 32'(exp_v));
         if (stall_prev) begin
            chk("hold data", 32'(out_data), 32'(hold_d));
            chk("hold last", 32'(out_last), 32'(hold_l));
         end
         if (out_valid && out_ready && mq.size() > 0) begin
            e = mq.pop_front();
            chk("data", 32'(out_data), 32'(e.d));
            chk("last", 32'(out_last), 32'(e.l));
            got.push_back(out_data);
            got_last.push_back(out_last);
         end
         stall_prev = out_valid && !out_ready;
         hold_d     = out_data;
         hold_l     = out_last;
         if (in_valid && in_ready) begin
            r = ref_op(in_op, in_a, in_b);
            if (in_acc) begin
               if (!m_first) r = ref_op(in_op, m_acc, r);
               m_acc = r;
            end
            m_first = in_last;
            e.d = r;
            e.l = in_last;
            e.acc_cyc = cyc;
            mq.push_back(e);
         end
      end
   end

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       input logic acc, input logic last);
      logic ok;
      int   n;
      in_a = a; in_b = b; in_op = op; in_acc = acc; in_last = last;
      in_valid = 1'b1;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 100) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) chk("accept timeout", 32'(ok), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (mq.size() > 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain", 32'(mq.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] t1_exp [4];
      t1_exp[0] = 8'h30; t1_exp[1] = 8'hFC; t1_exp[2] = 8'hCC; t1_exp[3] = 8'hC0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_data", 32'(out_data), 32'd0);
      chk("reset out_last", 32'(out_last), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single beats, each op, with latency check.
      for (int k = 0; k < 4; k++) begin
         send(8'hF0, 8'h3C, 2'(k), 1'b0, 1'b1);
         chk("latency early", 32'(out_valid), 32'd0);
         @(posedge clk);
         #1;
         chk("latency valid", 32'(out_valid), 32'd1);
         chk("op result", 32'(out_data), 32'(t1_exp[k]));
         drain();
      end

      // OR accumulate burst, then a fresh burst.
      got.delete(); got_last.delete();
      send(8'h01, 8'h00, 2'd1, 1'b1, 1'b0);
      send(8'h02, 8'h00, 2'd1, 1'b1, 1'b0);
      send(8'h80, 8'h00, 2'd1, 1'b1, 1'b1);
      send(8'h04, 8'h00, 2'd1, 1'b1, 1'b1);
      drain();
      chk("or burst 0", 32'(got[0]), 32'h01);
      chk("or burst 1", 32'(got[1]), 32'h03);
      chk("or burst 2", 32'(got[2]), 32'h83);
      chk("or burst last0", 32'(got_last[0]), 32'd0);
      chk("or burst last2", 32'(got_last[2]), 32'd1);
      chk("or new burst", 32'(got[3]), 32'h04);

      // AND accumulate burst; a non-accumulating beat leaves acc_reg alone.
      got.delete(); got_last.delete();
      send(8'hFF, 8'h0F, 2'd0, 1'b1, 1'b0);
      send(8'hF3, 8'hFF, 2'd0, 1'b1, 1'b1);
      send(8'h55, 8'h00, 2'd1, 1'b0, 1'b0);
      send(8'hFF, 8'hFF, 2'd0, 1'b1, 1'b1);
      drain();
      chk("and burst 0", 32'(got[0]), 32'h0F);
      chk("and burst 1", 32'(got[1]), 32'h03);
      chk("acc0 beat", 32'(got[2]), 32'h55);
      chk("acc kept", 32'(got[3]), 32'h03);

      // Random stream with pseudo-random backpressure.
      got.delete(); got_last.delete();
      fork
         begin
            for (int i = 0; i < 16; i++) begin
               send(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
         end
         begin
            for (int j = 0; j < 40; j++) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      out_ready = 1'b1;
      drain();
      chk("stream count", 32'(got.size()), 32'd16);

      // Reset in the middle of a stalled burst.
      out_ready = 1'b0;
      send(8'h01, 8'h00, 2'd1, 1'b1, 1'b0);
      send(8'h02, 8'h00, 2'd1, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("in_ready in reset", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("flushed out_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      got.delete(); got_last.delete();
      send(8'h10, 8'h00, 2'd1, 1'b1, 1'b1);
      drain();
      chk("post reset beat", 32'(got[0]), 32'h10);
      chk("post reset count", 32'(got.size()), 32'd1);

      // 32-bit, unregistered output.
      chk("w32 idle", 32'(out_valid2), 32'd0);
      in_a2 = 32'hDEADBEEF; in_b2 = 32'hFFFF0000; in_op2 = 2'd2; in_last2 = 1'b1;
      in_valid2 = 1'b1;
      @(posedge clk);
      #1;
      in_valid2 = 1'b0;
      chk("w32 valid", 32'(out_valid2), 32'd1);
      chk("w32 data", out_data2, 32'h2152BEEF);
      chk("w32 last", 32'(out_last2), 32'd1);
      @(posedge clk);
      #1;
      chk("w32 drained", 32'(out_valid2), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
